// File: rtl/supercar_pkg.sv
// Purpose: shared types and helpers for the supercar LED bar sequencer.
// Latency: n/a (types, constants and constant functions only).
// Backpressure: n/a.
package supercar_pkg;

    // Sweep sequencer states.
    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SCAN_UP = 2'd1,
        SCAN_DN = 2'd2,
        PAUSED  = 2'd3
    } scan_state_e;

    // Board default: clk cycles per step at the slowest speed level.
    localparam int unsigned BASE_DIV_DFLT = 1000000;

    // Divider counter width able to hold any period value up to base_div.
    function automatic int unsigned div_width(input int unsigned base_div);
        return $clog2(base_div + 1);
    endfunction

    // Step period for a speed level: the slowest level uses the full base
    // divisor and each level above it removes one (max_lvl+1)-th of it.
    // Clamped to 1 so a tiny base divisor never yields a zero-length period.
    function automatic int unsigned step_period(input int unsigned base_div,
                                                input int unsigned max_lvl,
                                                input int unsigned lvl);
        int unsigned p;
        p = (base_div * (max_lvl + 1 - lvl)) / (max_lvl + 1);
        return (p == 0) ? 1 : p;
    endfunction

endpackage : supercar_pkg

// File: rtl/btn_press_pulse.sv
// Purpose: turns a synchronised button level into a one-cycle press pulse.
// Latency: 1 clk from the 0->1 level change to the registered pulse.
// Backpressure: none; a held button produces exactly one pulse.
//
// Ports:
//   clk_i   - system clock, rising edge
//   rst_i   - synchronous reset, active-high
//   lvl_i   - synchronised button level
//   pulse_o - registered one-cycle press pulse
module btn_press_pulse (
    input  logic clk_i,
    input  logic rst_i,
    input  logic lvl_i,
    output logic pulse_o
);

    logic hist_q;
    logic pulse_q;

    // History resets to 1: a button already held when reset releases looks
    // like an old press, so it must be released and pressed again to count.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            hist_q  <= 1'b1;
            pulse_q <= 1'b0;
        end else begin
            hist_q  <= lvl_i;
            pulse_q <= lvl_i & ~hist_q;
        end
    end

    assign pulse_o = pulse_q;

endmodule : btn_press_pulse

// File: rtl/supercar_scan_ctrl.sv
// Purpose: supercar LED bar sequencer - one lit LED sweeps end to end and bounces.
// Latency: outputs registered, change 1 clk after the causing press pulse or tick.
// Backpressure: none; button presses are accepted in every state.
//
// Ports:
//   clk_i         - system clock, rising edge
//   rst_i         - synchronous reset, active-high
//   btn_start_i   - start/pause button level (synchronised)
//   btn_up_i      - speed-up button level (synchronised)
//   btn_dn_i      - speed-down button level (synchronised)
//   leds_o        - one-hot LED position, all zero in IDLE
//   running_o     - high while sweeping (SCAN_UP/SCAN_DN)
//   dir_o         - 1 = moving toward the MSB
//   speed_lvl_o   - current speed level, 0 = slowest
module supercar_scan_ctrl
    import supercar_pkg::*;
#(
    parameter int unsigned N_LEDS   = 8,
    parameter int unsigned BASE_DIV = BASE_DIV_DFLT,
    parameter int unsigned MAX_LVL  = 7,
    parameter int unsigned INIT_LVL = 0
) (
    input  logic                             clk_i,
    input  logic                             rst_i,
    input  logic                             btn_start_i,
    input  logic                             btn_up_i,
    input  logic                             btn_dn_i,
    output logic [N_LEDS-1:0]                leds_o,
    output logic                             running_o,
    output logic                             dir_o,
    output logic [$clog2(MAX_LVL+1)-1:0]     speed_lvl_o
);

    localparam int unsigned LVL_W = $clog2(MAX_LVL + 1);
    localparam int unsigned CNT_W = div_width(BASE_DIV);

    // ------------------------------------------------------------------
    // Press pulses
    // ------------------------------------------------------------------
    logic start_p;
    logic up_p;
    logic dn_p;

    btn_press_pulse u_start (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .lvl_i   (btn_start_i),
        .pulse_o (start_p)
    );

    btn_press_pulse u_up (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .lvl_i   (btn_up_i),
        .pulse_o (up_p)
    );

    btn_press_pulse u_dn (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .lvl_i   (btn_dn_i),
        .pulse_o (dn_p)
    );

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    scan_state_e        state_q;
    logic [N_LEDS-1:0]  leds_q;
    logic               running_q;
    logic               dir_q;
    logic [LVL_W-1:0]   lvl_q;
    logic [LVL_W-1:0]   lvl_d;
    logic               lvl_chg;
    logic [CNT_W-1:0]   cnt_q;
    logic [CNT_W-1:0]   per_m1;
    logic               tick;

    // Speed level next state: simultaneous up and dn cancel, both ends saturate.
    always_comb begin
        lvl_d = lvl_q;
        if (up_p && !dn_p && (lvl_q != LVL_W'(MAX_LVL))) begin
            lvl_d = lvl_q + 1'b1;
        end else if (dn_p && !up_p && (lvl_q != '0)) begin
            lvl_d = lvl_q - 1'b1;
        end
    end

    assign lvl_chg = (lvl_d != lvl_q);

    // Terminal count of the divider for the current level.
    assign per_m1 = CNT_W'(step_period(BASE_DIV, MAX_LVL, int'(lvl_q)) - 1);

    // running_q mirrors the SCAN_* states, so it gates the divider directly.
    assign tick = running_q && (cnt_q == per_m1);

    // ------------------------------------------------------------------
    // Sweep FSM, LED shift register, speed register and step divider
    // ------------------------------------------------------------------
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q   <= IDLE;
            leds_q    <= '0;
            running_q <= 1'b0;
            dir_q     <= 1'b1;
            lvl_q     <= LVL_W'(INIT_LVL);
            cnt_q     <= '0;
        end else begin
            lvl_q <= lvl_d;

            case (state_q)
                IDLE: begin
                    if (start_p) begin
                        state_q   <= SCAN_UP;
                        leds_q    <= {{(N_LEDS-1){1'b0}}, 1'b1};
                        running_q <= 1'b1;
                        dir_q     <= 1'b1;
                    end
                end

                SCAN_UP, SCAN_DN: begin
                    // A start press beats a coincident tick: pause without shifting.
                    if (start_p) begin
                        state_q   <= PAUSED;
                        running_q <= 1'b0;
                    end else if (tick) begin
                        if (state_q == SCAN_UP) begin
                            leds_q <= leds_q << 1;
                            // Turn around on arrival so the end LED is lit
                            // for one full period, never skipped or doubled.
                            if (leds_q[N_LEDS-2]) begin
                                state_q <= SCAN_DN;
                                dir_q   <= 1'b0;
                            end
                        end else begin
                            leds_q <= leds_q >> 1;
                            if (leds_q[1]) begin
                                state_q <= SCAN_UP;
                                dir_q   <= 1'b1;
                            end
                        end
                    end
                end

                PAUSED: begin
                    if (start_p) begin
                        state_q   <= dir_q ? SCAN_UP : SCAN_DN;
                        running_q <= 1'b1;
                    end
                end

                default: begin
                    state_q <= IDLE;
                end
            endcase

            // Divider: a level change restarts the period so the new, possibly
            // shorter, period cannot be overrun. Pausing and resuming freeze
            // the count for that cycle so the sweep picks up where it stopped.
            if (lvl_chg || (state_q == IDLE)) begin
                cnt_q <= '0;
            end else if (running_q && !start_p) begin
                cnt_q <= tick ? '0 : cnt_q + 1'b1;
            end
        end
    end

    assign leds_o      = leds_q;
    assign running_o   = running_q;
    assign dir_o       = dir_q;
    assign speed_lvl_o = lvl_q;

endmodule : supercar_scan_ctrl

// File: tb/tb_supercar_scan_ctrl.sv
// Purpose: scoreboard bench for supercar_scan_ctrl (N_LEDS=4, BASE_DIV=16, MAX_LVL=3).
// Latency: expectations carry the absolute cycle at which each output change must appear.
// Backpressure: n/a.
module tb_supercar_scan_ctrl;

    localparam int LVL_W = 2;

    logic             clk;
    logic             rst;
    logic             btn_start;
    logic             btn_up;
    logic             btn_dn;
    logic [3:0]       leds;
    logic             running;
    logic             dir;
    logic [LVL_W-1:0] speed_lvl;

    supercar_scan_ctrl #(
        .N_LEDS   (4),
        .BASE_DIV (16),
        .MAX_LVL  (3),
        .INIT_LVL (0)
    ) dut (
        .clk_i       (clk),
        .rst_i       (rst),
        .btn_start_i (btn_start),
        .btn_up_i    (btn_up),
        .btn_dn_i    (btn_dn),
        .leds_o      (leds),
        .running_o   (running),
        .dir_o       (dir),
        .speed_lvl_o (speed_lvl)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Number of rising edges seen so far.
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [3:0]       leds;
        logic             dir;
        logic             run;
        logic [LVL_W-1:0] lvl;
        int               cyc;
    } exp_t;

    exp_t sb[$];
    int   applied     = 0;
    int   miscompares = 0;

    task automatic expect_at(input logic [3:0] l, input logic d, input logic r,
                             input logic [LVL_W-1:0] v, input int c);
        exp_t e;
        e.leds = l; e.dir = d; e.run = r; e.lvl = v; e.cyc = c;
        sb.push_back(e);
    endtask

    // Advance to just after rising edge number c.
    task automatic at(input int c);
        while (cyc < c) begin
            @(posedge clk);
            #1;
        end
    endtask

    // One-cycle press: 0 = start, 1 = up, 2 = dn, 3 = up and dn together.
    task automatic press(input int which, input int n);
        at(n);
        case (which)
            0: btn_start = 1'b1;
            1: btn_up    = 1'b1;
            2: btn_dn    = 1'b1;
            default: begin btn_up = 1'b1; btn_dn = 1'b1; end
        endcase
        at(n + 1);
        btn_start = 1'b0;
        btn_up    = 1'b0;
        btn_dn    = 1'b0;
    endtask

    // Monitor: every change of the output tuple is one observed response.
    logic [7:0] prev = 'x;
    logic [7:0] cur;
    always @(negedge clk) begin
        exp_t e;
        cur = {leds, dir, running, speed_lvl};
        if (cur !== prev) begin
            prev = cur;
            applied++;
            if (sb.size() == 0) begin
                miscompares++;
                $display("FAIL unexpected_change cyc=%0d got leds=%b dir=%b run=%b lvl=%0d, none expected",
                         cyc, leds, dir, running, speed_lvl);
            end else begin
                e = sb.pop_front();
                if (cur !== {e.leds, e.dir, e.run, e.lvl} || cyc != e.cyc) begin
                    miscompares++;
                    $display("FAIL output_step got cyc=%0d leds=%b dir=%b run=%b lvl=%0d, want cyc=%0d leds=%b dir=%b run=%b lvl=%0d",
                             cyc, leds, dir, running, speed_lvl,
                             e.cyc, e.leds, e.dir, e.run, e.lvl);
                end
            end
        end
    end

    initial begin
        exp_t e;
        rst = 1'b1; btn_start = 1'b0; btn_up = 1'b0; btn_dn = 1'b0;

        // Reset state appears at the first edge.
        expect_at(4'b0000, 1, 0, 0, 1);
        at(3);
        rst = 1'b0;

        // 1: start, then one step every 16 clk with bounce at both ends.
        expect_at(4'b0001, 1, 1, 0, 7);
        expect_at(4'b0010, 1, 1, 0, 23);
        expect_at(4'b0100, 1, 1, 0, 39);
        expect_at(4'b1000, 0, 1, 0, 55);
        expect_at(4'b0100, 0, 1, 0, 71);
        expect_at(4'b0010, 0, 1, 0, 87);
        expect_at(4'b0001, 1, 1, 0, 103);
        expect_at(4'b0010, 1, 1, 0, 119);
        press(0, 5);

        // 2: up x4 saturates at 3 (step every 4 clk), dn x4 back to 0 (16 clk).
        expect_at(4'b0010, 1, 1, 1, 121);
        expect_at(4'b0010, 1, 1, 2, 123);
        expect_at(4'b0010, 1, 1, 3, 125);
        expect_at(4'b0100, 1, 1, 3, 129);
        expect_at(4'b1000, 0, 1, 3, 133);
        expect_at(4'b0100, 0, 1, 3, 137);
        expect_at(4'b0100, 0, 1, 2, 139);
        expect_at(4'b0100, 0, 1, 1, 141);
        expect_at(4'b0100, 0, 1, 0, 143);
        expect_at(4'b0010, 0, 1, 0, 159);
        expect_at(4'b0001, 1, 1, 0, 175);
        press(1, 119);
        press(1, 121);
        press(1, 123);
        press(1, 125);
        press(2, 137);
        press(2, 139);
        press(2, 141);
        press(2, 143);

        // 3: pause at 0100 going down with count 3, resume 13 clk before the step.
        expect_at(4'b0010, 1, 1, 0, 191);
        expect_at(4'b0100, 1, 1, 0, 207);
        expect_at(4'b1000, 0, 1, 0, 223);
        expect_at(4'b0100, 0, 1, 0, 239);
        expect_at(4'b0100, 0, 0, 0, 243);
        expect_at(4'b0100, 0, 1, 0, 295);
        expect_at(4'b0010, 0, 1, 0, 308);
        expect_at(4'b0001, 1, 1, 0, 324);
        press(0, 241);
        press(0, 293);

        // 4: start held 40 clk pauses once; up+dn together leaves the level
        //    and the held count alone, so the step after resume is 14 clk out.
        expect_at(4'b0001, 1, 0, 0, 327);
        expect_at(4'b0001, 1, 1, 0, 376);
        expect_at(4'b0010, 1, 1, 0, 390);
        at(325);
        btn_start = 1'b1;
        at(365);
        btn_start = 1'b0;
        press(3, 369);
        press(0, 374);

        // 5: start on a tick pauses without shifting; resume ticks at once.
        //    Up on a tick shifts and restarts with the 12 clk period.
        expect_at(4'b0010, 1, 0, 0, 406);
        expect_at(4'b0010, 1, 1, 0, 412);
        expect_at(4'b0100, 1, 1, 0, 413);
        expect_at(4'b1000, 0, 1, 1, 429);
        expect_at(4'b0100, 0, 1, 1, 441);
        expect_at(4'b0010, 0, 1, 1, 453);
        expect_at(4'b0001, 1, 1, 1, 465);
        expect_at(4'b0010, 1, 1, 1, 477);
        expect_at(4'b0100, 1, 1, 1, 489);
        expect_at(4'b1000, 0, 1, 1, 501);
        press(0, 404);
        press(0, 410);
        press(1, 427);

        // 6: reset at 1000 with start held; no press until release and re-press.
        expect_at(4'b0000, 1, 0, 0, 504);
        expect_at(4'b0001, 1, 1, 0, 522);
        expect_at(4'b0010, 1, 1, 0, 538);
        at(503);
        rst       = 1'b1;
        btn_start = 1'b1;
        at(506);
        rst = 1'b0;
        at(516);
        btn_start = 1'b0;
        press(0, 520);

        at(545);
        while (sb.size() != 0) begin
            e = sb.pop_front();
            applied++;
            miscompares++;
            $display("FAIL missing_change got nothing by cyc=%0d, want cyc=%0d leds=%b dir=%b run=%b lvl=%0d",
                     cyc, e.cyc, e.leds, e.dir, e.run, e.lvl);
        end

        $display("== %0d vectors applied, %0d miscompares ==", applied, miscompares);
        $finish;
    end

endmodule : tb_supercar_scan_ctrl
